fila_circular: RTL and testbench

FILA_CIRCULAR -- requirements
Module: fila_circular

---
 rtl/fila_pkg.sv | 12 +
 rtl/fila_ptr.sv | 36 +++
 rtl/fila_circular.sv | 130 +++++++++++++
 tb/tb_fila_circular.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared defaults and the pointer-width helper for the fila_circular queue.
package fila_pkg;

    localparam int FILA_DATA_W = 8;
    localparam int FILA_DEPTH  = 8;

    // Width of a head/tail pointer that indexes 0..depth-1 (never zero bits).
    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fila_ptr.sv
// Registered queue pointer: advances by one on adv_in and wraps DEPTH-1 -> 0.
module fila_ptr
    import fila_pkg::*;
#(
    parameter int DEPTH = FILA_DEPTH,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_in,
    output logic [PTR_W-1:0] ptr_out
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_in) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_out = ptr_q;

endmodule

// File: rtl/fila_circular.sv
// Circular FIFO with registered read data and sticky error flags.
// Define FILA_CIRCULAR_ERR_EN to build the overflow/underflow flag logic.
module fila_circular
    import fila_pkg::*;
#(
    parameter int DATA_W    = FILA_DATA_W,
    parameter int DEPTH     = FILA_DEPTH,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                       clk_10KHz,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       enqueue_in,
    input  logic                       dequeue_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] AFULL_L = LEN_W'(AFULL_LVL);

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LEN_W-1:0]  len_d, len_q;
    logic [DATA_W-1:0] data_out_d, data_out_q;
    logic              data_valid_d, data_valid_q;
    logic [PTR_W-1:0]  head_ptr, tail_ptr;
    logic              enq_acc, deq_acc;

    // Handshake: a request is taken on the rising edge where its *_acc term is
    // high; a dequeue needs a stored entry, an enqueue needs room or a
    // same-edge dequeue. An empty queue never forwards data_in to data_out.
    assign deq_acc = dequeue_in && (len_q != '0);
    assign enq_acc = enqueue_in && ((len_q != DEPTH_L) || deq_acc);

    fila_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
        .clk     (clk_10KHz),
        .reset   (reset),
        .adv_in  (deq_acc),
        .ptr_out (head_ptr)
    );

    fila_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
        .clk     (clk_10KHz),
        .reset   (reset),
        .adv_in  (enq_acc),
        .ptr_out (tail_ptr)
    );

    always_comb begin
        mem_d = mem_q;
        if (enq_acc) begin
            mem_d[tail_ptr] = data_in;
        end
    end

    always_comb begin
        len_d        = len_q;
        data_out_d   = data_out_q;
        data_valid_d = deq_acc;
        if (enq_acc && !deq_acc) begin
            len_d = len_q + LEN_W'(1);
        end else if (deq_acc && !enq_acc) begin
            len_d = len_q - LEN_W'(1);
        end
        if (deq_acc) begin
            data_out_d = mem_q[head_ptr];
        end
    end

    // Storage is not reset; only entries between head and tail are ever read.
    always_ff @(posedge clk_10KHz) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            len_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            len_q        <= len_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

`ifdef FILA_CIRCULAR_ERR_EN
    logic overflow_d, overflow_q;
    logic underflow_d, underflow_q;

    // A dequeue on an empty queue that is paired with an enqueue is not an error.
    always_comb begin
        overflow_d  = overflow_q  || (enqueue_in && !enq_acc);
        underflow_d = underflow_q || (dequeue_in && !deq_acc && !enq_acc);
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign len_out     = len_q;
    assign full        = (len_q == DEPTH_L);
    assign empty       = (len_q == '0);
    assign almost_full = (len_q >= AFULL_L);

endmodule

// File: tb/tb_fila_circular.sv
// Self-checking bench for fila_circular (DATA_W=8, DEPTH=8, AFULL_LVL=7).
`timescale 1ns/1ps
module tb_fila_circular;

    localparam int DEPTH = 8;
`ifdef FILA_CIRCULAR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_10KHz;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic [3:0] len_out;
    logic       full, empty, almost_full, overflow, underflow;

    int vec_cnt;
    int err_cnt;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    logic       m_valid;
    logic [7:0] m_dout;
    logic       m_ovf, m_udf;
    logic [7:0] got;

    fila_circular #(.DATA_W(8), .DEPTH(8), .AFULL_LVL(7)) dut (
        .clk_10KHz   (clk_10KHz),
        .reset       (reset),
        .data_in     (data_in),
        .enqueue_in  (enqueue_in),
        .dequeue_in  (dequeue_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .len_out     (len_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // clock/reset block
    initial begin
        clk_10KHz = 1'b0;
        forever #50 clk_10KHz = ~clk_10KHz;
    end

    // driver: one clock cycle of stimulus; updates the reference model
    task automatic drive(input logic enq, input logic deq, input logic [7:0] din);
        logic deq_ok, enq_ok;
        deq_ok = deq && (model_q.size() != 0);
        enq_ok = enq && ((model_q.size() < DEPTH) || deq_ok);
        enqueue_in = enq;
        dequeue_in = deq;
        data_in    = din;
        @(posedge clk_10KHz);
        #1;
        m_valid = deq_ok;
        if (deq_ok) begin
            m_dout = model_q.pop_front();
            exp_q.push_back(m_dout);
        end
        if (enq_ok) model_q.push_back(din);
        if (ERR_EN && enq && !enq_ok) m_ovf = 1'b1;
        if (ERR_EN && deq && !deq_ok && !enq_ok) m_udf = 1'b1;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk_10KHz);
        #1;
        reset = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_dout  = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enqueue_in = 1'b1; dequeue_in = 1'b1; data_in = 8'hC3;
        repeat (2) @(posedge clk_10KHz);
        #1;
        vec_cnt++;
        if ({len_out, empty, full, almost_full, data_valid, data_out, overflow, underflow} !==
            {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL reset_state: len=%0d empty=%b full=%b af=%b dv=%b dout=%h ovf=%b udf=%b, required len=0 empty=1 others 0",
                     len_out, empty, full, almost_full, data_valid, data_out, overflow, underflow);
        end
        enqueue_in = 1'b0; dequeue_in = 1'b0;
        apply_reset();
    endtask

    task automatic test_basic();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, vals[i]);
            vec_cnt++;
            if (len_out !== 4'(i + 1) || empty !== 1'b0 || data_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL basic_enq%0d: len=%0d empty=%b dv=%b, required len=%0d empty=0 dv=0",
                         i, len_out, empty, data_valid, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            got = exp_q.pop_front();
            vec_cnt++;
            if (data_valid !== 1'b1 || data_out !== got || data_out !== vals[i] || len_out !== 4'(2 - i)) begin
                err_cnt++;
                $display("FAIL basic_deq%0d: dv=%b dout=%h len=%0d, required dv=1 dout=%h len=%0d",
                         i, data_valid, data_out, len_out, vals[i], 2 - i);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        vec_cnt++;
        if (data_valid !== 1'b0 || empty !== 1'b1 || len_out !== 4'd0 || data_out !== 8'h33) begin
            err_cnt++;
            $display("FAIL basic_idle: dv=%b empty=%b len=%0d dout=%h, required dv=0 empty=1 len=0 dout=33",
                     data_valid, empty, len_out, data_out);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            vec_cnt++;
            if (len_out !== 4'(i + 1) || almost_full !== (i + 1 >= 7) || full !== (i + 1 == 8)) begin
                err_cnt++;
                $display("FAIL fill_len%0d: len=%0d af=%b full=%b, required len=%0d af=%b full=%b",
                         i + 1, len_out, almost_full, full, i + 1, (i + 1 >= 7), (i + 1 == 8));
            end
        end
        drive(1'b1, 1'b0, 8'hAA);
        vec_cnt++;
        if (len_out !== 4'd8 || full !== 1'b1 || overflow !== ERR_EN || underflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL overflow: len=%0d full=%b ovf=%b udf=%b, required len=8 full=1 ovf=%b udf=0",
                     len_out, full, overflow, underflow, ERR_EN);
        end
    endtask

    task automatic test_full_both();
        drive(1'b1, 1'b1, 8'h55);
        got = exp_q.pop_front();
        vec_cnt++;
        if (len_out !== 4'd8 || data_valid !== 1'b1 || data_out !== got) begin
            err_cnt++;
            $display("FAIL full_both: len=%0d dv=%b dout=%h, required len=8 dv=1 dout=%h",
                     len_out, data_valid, data_out, got);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            got = exp_q.pop_front();
            vec_cnt++;
            if (data_valid !== 1'b1 || data_out !== got || len_out !== 4'(7 - i)) begin
                err_cnt++;
                $display("FAIL drain%0d: dv=%b dout=%h len=%0d, required dv=1 dout=%h len=%0d",
                         i, data_valid, data_out, len_out, got, 7 - i);
            end
        end
        vec_cnt++;
        if (data_out !== 8'h55 || empty !== 1'b1) begin
            err_cnt++;
            $display("FAIL wrap_last: dout=%h empty=%b, required dout=55 empty=1", data_out, empty);
        end
    endtask

    task automatic test_empty_both();
        apply_reset();
        drive(1'b1, 1'b1, 8'h77);
        vec_cnt++;
        if (data_valid !== 1'b0 || underflow !== 1'b0 || len_out !== 4'd1 || data_out !== 8'h00) begin
            err_cnt++;
            $display("FAIL empty_both: dv=%b udf=%b len=%0d dout=%h, required dv=0 udf=0 len=1 dout=00",
                     data_valid, underflow, len_out, data_out);
        end
        drive(1'b0, 1'b1, 8'h00);
        got = exp_q.pop_front();
        vec_cnt++;
        if (data_valid !== 1'b1 || data_out !== 8'h77 || got !== 8'h77 || len_out !== 4'd0) begin
            err_cnt++;
            $display("FAIL empty_both_out: dv=%b dout=%h len=%0d, required dv=1 dout=77 len=0",
                     data_valid, data_out, len_out);
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, 8'h00);
        vec_cnt++;
        if (data_valid !== 1'b0 || data_out !== 8'h77 || underflow !== ERR_EN || overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL underflow: dv=%b dout=%h udf=%b ovf=%b, required dv=0 dout=77 udf=%b ovf=0",
                     data_valid, data_out, underflow, overflow, ERR_EN);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            vec_cnt++;
            if (data_valid !== m_valid || data_out !== m_dout || len_out !== 4'(model_q.size()) ||
                full !== (model_q.size() == 8) || empty !== (model_q.size() == 0) ||
                almost_full !== (model_q.size() >= 7) || overflow !== m_ovf || underflow !== m_udf) begin
                err_cnt++;
                $display("FAIL random%0d: dv=%b dout=%h len=%0d f=%b e=%b af=%b ovf=%b udf=%b, required dv=%b dout=%h len=%0d ovf=%b udf=%b",
                         n, data_valid, data_out, len_out, full, empty, almost_full, overflow, underflow,
                         m_valid, m_dout, model_q.size(), m_ovf, m_udf);
            end
            if (m_valid) got = exp_q.pop_front();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
        drive(1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 8'h00);
        reset = 1'b1; enqueue_in = 1'b1; dequeue_in = 1'b1; data_in = 8'hEE;
        @(posedge clk_10KHz);
        #1;
        vec_cnt++;
        if (len_out !== 4'd0 || empty !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid: len=%0d empty=%b dv=%b dout=%h ovf=%b udf=%b, required len=0 empty=1 dv=0 dout=00 flags 0",
                     len_out, empty, data_valid, data_out, overflow, underflow);
        end
        enqueue_in = 1'b0; dequeue_in = 1'b0;
        apply_reset();
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        reset = 1'b1; enqueue_in = 1'b0; dequeue_in = 1'b0; data_in = 8'h00;
        m_valid = 1'b0; m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_both();
        test_empty_both();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
